// File: rtl/bram_pkg.sv
// +-----------------------------------------------------------------------------+
// | bram_pkg : shared types, constants and helpers for the bram_slave RAM slave |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

package bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

    function automatic int idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_byte_array.sv
// +-----------------------------------------------------------------------------+
// | bram_byte_array : DEPTH_WORDS x 32 storage, byte-lane write, registered read |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module bram_byte_array
    import bram_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int INIT_PATTERN = 1,
    parameter int IDX_W        = idx_width(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             we_i,
    input  logic [3:0]       wstrb_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic             rclr_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    typedef logic [DEPTH_WORDS-1:0][31:0] image_t;

    function automatic image_t init_image();
        image_t img;
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            img[i] = (INIT_PATTERN == 1) ? 32'(i) : 32'h0;
        end
        return img;
    endfunction

    // Power-up image only; reset deliberately leaves the contents alone.
    image_t      mem_q = init_image();
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_i[k]) begin
                    mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rdata_q <= '0;
        end else if (rclr_i) begin
            rdata_q <= OOR_RDATA;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bram_slave.sv
// +-----------------------------------------------------------------------------+
// | bram_slave : native-bus RAM slave with chip select, byte strobes, latency   |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module bram_slave
    import bram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1,
    parameter int          INIT_PATTERN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_cs,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int               IDX_W      = idx_width(DEPTH_WORDS);
    localparam int               CNT_W      = 3;
    localparam logic [32:0]      ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(READ_LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_range_q, in_range_d;
    logic             is_write_q, is_write_d;

    logic             w_accept, w_in_range, w_is_write, w_we, w_re, w_rclr;
    logic [IDX_W-1:0] w_idx, w_raddr;

    assign w_accept   = reset_n && (state_q == IDLE) && mem_cs && mem_valid;
    // 33-bit limit so a region ending at the top of the address map still compares correctly.
    assign w_in_range = (mem_addr >= ADDR_BASE) && ({1'b0, mem_addr} < ADDR_LIMIT);
    assign w_is_write = |mem_wstrb;
    assign w_idx      = mem_addr[IDX_W+1:2];
    assign w_we       = w_accept && w_in_range && w_is_write;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        is_write_d = is_write_q;
        w_raddr    = idx_q;
        w_re       = 1'b0;
        w_rclr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    idx_d      = w_idx;
                    in_range_d = w_in_range;
                    is_write_d = w_is_write;
                    if (READ_LATENCY == 1) begin
                        state_d = RESP;
                        w_raddr = w_idx;
                        w_re    = w_in_range && !w_is_write;
                        w_rclr  = !w_in_range;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = RESP;
                    w_re    = in_range_q && !is_write_q;
                    w_rclr  = !in_range_q;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            is_write_q <= is_write_d;
        end
    end

    bram_byte_array #(
        .DEPTH_WORDS  (DEPTH_WORDS),
        .INIT_PATTERN (INIT_PATTERN),
        .IDX_W        (IDX_W)
    ) u_array (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .we_i     (w_we),
        .wstrb_i  (mem_wstrb),
        .waddr_i  (w_idx),
        .wdata_i  (mem_wdata),
        .re_i     (w_re),
        .rclr_i   (w_rclr),
        .raddr_i  (w_raddr),
        .rdata_o  (mem_rdata)
    );

    assign mem_ready = (state_q == RESP);
    assign mem_err   = (state_q == RESP) && !in_range_q;

endmodule

`default_nettype wire
